// File: rtl/i2c_pkg.sv
// Shared state encoding, quarter-phase constants and helpers for the i2c_master bus driver.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ACK_A,
        REG,
        ACK_R,
        WDATA,
        ACK_D,
        RDATA,
        MNACK,
        STOP,
        DONE
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

    localparam int WR_SLOTS   = 29;
    localparam int RD_SLOTS   = 20;
    localparam int NACK_SLOTS = 11;

    // Acknowledge slot that follows each master-transmitted byte.
    function automatic state_t ack_after(input state_t s);
        case (s)
            ADDR:    return ACK_A;
            REG:     return ACK_R;
            default: return ACK_D;
        endcase
    endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-SCL-period divider: pulses tick every CLK_DIV clocks and steps a 2-bit phase.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [QW-1:0] cnt;

    assign tick = en && (cnt == QW'(CLK_DIV - 1));

    // Held at zero while disabled so every transaction starts on a fresh Q0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C register-access driver: START / addr+RW / reg / data / STOP, or a one-byte read.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev_addr,
    input  logic [7:0] cmd_reg_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic       rsp_nack,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       SCL,
    inout  wire        SDA
);

    state_t     state;
    logic       run;
    logic       tick;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic       rw_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic       sda_low;

    assign SDA       = sda_low ? 1'b0 : 1'bz;
    assign run       = (state != IDLE);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (run),
        .tick  (tick),
        .phase (phase)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            SCL       <= 1'b1;
            sda_low   <= 1'b0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rw_q      <= I2C_WR;
            reg_q     <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_nack  <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state    <= START;
                        tx_shift <= {cmd_dev_addr, cmd_rw};
                        rw_q     <= cmd_rw;
                        reg_q    <= cmd_reg_addr;
                        wdata_q  <= cmd_wdata;
                        rsp_nack <= 1'b0;
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    if (tick) begin
                        case (phase)
                            Q0: begin
                                if (state inside {ADDR, REG, WDATA})
                                    sda_low <= ~tx_shift[7];
                                else if (state inside {ACK_A, ACK_R, ACK_D, RDATA, MNACK})
                                    sda_low <= 1'b0;
                            end
                            Q1: begin
                                SCL <= 1'b1;
                                if (state == START) sda_low <= 1'b1;
                            end
                            Q2: begin
                                if (state == STOP) sda_low <= 1'b0;
                                if (state == RDATA) rx_shift <= {rx_shift[6:0], SDA};
                                if (state inside {ACK_A, ACK_R, ACK_D} && SDA) rsp_nack <= 1'b1;
                            end
                            default: begin
                                // End of slot: SCL falls (except leaving STOP) and the sequence advances.
                                SCL <= (state == STOP);
                                case (state)
                                    START: begin
                                        state   <= ADDR;
                                        bit_cnt <= '0;
                                    end
                                    ADDR, REG, WDATA: begin
                                        tx_shift <= {tx_shift[6:0], 1'b0};
                                        bit_cnt  <= bit_cnt + 3'd1;
                                        if (bit_cnt == 3'd7) state <= ack_after(state);
                                    end
                                    RDATA: begin
                                        bit_cnt <= bit_cnt + 3'd1;
                                        if (bit_cnt == 3'd7) state <= MNACK;
                                    end
                                    ACK_A: begin
                                        bit_cnt <= '0;
                                        if (rsp_nack) begin
                                            state   <= STOP;
                                            sda_low <= 1'b1;
                                        end else if (rw_q == I2C_RD) begin
                                            state <= RDATA;
                                        end else begin
                                            state    <= REG;
                                            tx_shift <= reg_q;
                                        end
                                    end
                                    ACK_R: begin
                                        bit_cnt <= '0;
                                        if (rsp_nack) begin
                                            state   <= STOP;
                                            sda_low <= 1'b1;
                                        end else begin
                                            state    <= WDATA;
                                            tx_shift <= wdata_q;
                                        end
                                    end
                                    ACK_D, MNACK: begin
                                        state   <= STOP;
                                        sda_low <= 1'b1;
                                    end
                                    STOP: begin
                                        state     <= DONE;
                                        rsp_valid <= 1'b1;
                                        if (rw_q == I2C_RD && !rsp_nack) rsp_rdata <= rx_shift;
                                    end
                                    default: state <= IDLE;
                                endcase
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a behavioural register slave at 7'h2A and a bus protocol monitor.
module tb_i2c_master;

    localparam int         CLK_DIV    = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h2A;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_dev_addr = '0;
    logic [7:0] cmd_reg_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       cmd_ready;
    logic       rsp_valid;
    logic       rsp_nack;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       scl;
    wire        sda;

    int errors = 0;
    int checks = 0;

    pullup (sda);

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_dev_addr (cmd_dev_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_nack     (rsp_nack),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .SCL          (scl),
        .SDA          (sda)
    );

    always #5 clk = ~clk;

    // Behavioural slave: reg pointer set by the first written byte, data byte stored at the pointer.
    logic [7:0] mem [0:255];
    logic [7:0] ptr = '0;
    logic       s_pull = 1'b0;
    logic       s_active = 1'b0;
    logic       s_first = 1'b0;
    logic       s_match = 1'b0;
    logic       s_rw = 1'b0;
    logic       s_tx = 1'b0;
    int         s_bit = 0;
    int         s_byte = 0;
    logic [7:0] s_shift = '0;
    logic [7:0] s_tx_byte = '0;
    logic [7:0] bus_q [$];
    logic       ack_q [$];
    int         scl_rises = 0;
    int         starts = 0;
    int         stops = 0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;

    assign sda = s_pull ? 1'b0 : 1'bz;

    always @(negedge sda) begin
        if (scl === 1'b1) begin
            s_active = 1'b1; s_first = 1'b1; s_bit = 0; s_byte = 0;
            s_tx = 1'b0; s_match = 1'b0; s_pull = 1'b0;
        end
    end

    always @(posedge sda) begin
        if (scl === 1'b1) begin
            s_active = 1'b0; s_pull = 1'b0;
        end
    end

    always @(posedge scl) begin
        scl_rises++;
        if (s_active) begin
            if (s_bit < 8) s_shift = {s_shift[6:0], (sda === 1'b0) ? 1'b0 : 1'b1};
            else ack_q.push_back((sda === 1'b0) ? 1'b0 : 1'b1);
        end
    end

    always @(negedge scl) begin
        if (s_active) begin
            if (s_first) begin
                s_first = 1'b0;
            end else if (s_bit == 7) begin
                s_bit = 8;
                bus_q.push_back(s_shift);
                if (s_tx) begin
                    s_pull = 1'b0;
                end else if (s_byte == 0) begin
                    s_match = (s_shift[7:1] == SLAVE_ADDR);
                    s_rw    = s_shift[0];
                    s_pull  = s_match;
                end else begin
                    if (s_byte == 1) ptr = s_shift;
                    else mem[ptr] = s_shift;
                    s_pull = 1'b1;
                end
            end else if (s_bit == 8) begin
                s_pull = 1'b0; s_bit = 0; s_byte++;
                if (!s_match) begin
                    s_active = 1'b0;
                end else if (s_rw && !s_tx && s_byte == 1) begin
                    s_tx = 1'b1; s_tx_byte = mem[ptr]; s_pull = ~s_tx_byte[7];
                end else begin
                    s_tx = 1'b0;
                end
            end else begin
                s_bit++;
                if (s_tx) s_pull = ~s_tx_byte[7 - s_bit];
            end
        end
    end

    // SDA edges while SCL stays high are START (falling) or STOP (rising) conditions.
    always @(negedge clk) begin
        if (rst === 1'b1 && prev_scl === 1'b1 && scl === 1'b1 && sda !== prev_sda) begin
            if (sda === 1'b0) starts++;
            else stops++;
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] bus_word();
        logic [31:0] w = '0;
        foreach (bus_q[i]) w = {w[23:0], bus_q[i]};
        return w;
    endfunction

    function automatic logic [7:0] ack_word();
        logic [7:0] w = '0;
        foreach (ack_q[i]) w = {w[6:0], ack_q[i]};
        return w;
    endfunction

    task automatic clear_mon();
        bus_q.delete(); ack_q.delete();
        scl_rises = 0; starts = 0; stops = 0;
    endtask

    task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, output int lat);
        int wait_cyc;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_wdata = wd;
        wait_cyc = 0;
        while (cmd_ready !== 1'b1 && wait_cyc < 1000) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl got=%b exp=1", scl); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got=%b exp=1", sda); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_nack !== 1'b0) begin errors++; $display("FAIL reset_rsp_nack got=%b exp=0", rsp_nack); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=00", rsp_rdata); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int lat;
        clear_mon();
        run_cmd(1'b0, 7'h2A, 8'h03, 8'hA5, lat);
        checks++; if (lat !== 465) begin errors++; $display("FAIL write_latency got=%0d exp=465", lat); end
        checks++; if (rsp_nack !== 1'b0) begin errors++; $display("FAIL write_nack got=%b exp=0", rsp_nack); end
        checks++; if (bus_q.size() !== 3) begin errors++; $display("FAIL write_byte_count got=%0d exp=3", bus_q.size()); end
        checks++; if (bus_word() !== 32'h005403A5) begin errors++; $display("FAIL write_bytes got=%h exp=005403a5", bus_word()); end
        checks++; if (ack_word() !== 8'h00 || ack_q.size() !== 3) begin errors++; $display("FAIL write_acks got=%b/%0d exp=000/3", ack_word(), ack_q.size()); end
        checks++; if (scl_rises !== 28) begin errors++; $display("FAIL write_scl_rises got=%0d exp=28", scl_rises); end
        checks++; if (mem[3] !== 8'hA5) begin errors++; $display("FAIL write_slave_mem got=%h exp=a5", mem[3]); end
        repeat (3) @(negedge clk);
        checks++; if (scl !== 1'b1 || sda !== 1'b1) begin errors++; $display("FAIL write_idle_bus got=%b%b exp=11", scl, sda); end
        checks++; if (starts !== 1 || stops !== 1) begin errors++; $display("FAIL write_start_stop got=%0d/%0d exp=1/1", starts, stops); end
    endtask

    task automatic test_read();
        int lat;
        mem[3] = 8'h5C;
        clear_mon();
        run_cmd(1'b1, 7'h2A, 8'hFF, 8'h00, lat);
        checks++; if (lat !== 321) begin errors++; $display("FAIL read_latency got=%0d exp=321", lat); end
        checks++; if (rsp_rdata !== 8'h5C) begin errors++; $display("FAIL read_rdata got=%h exp=5c", rsp_rdata); end
        checks++; if (rsp_nack !== 1'b0) begin errors++; $display("FAIL read_nack got=%b exp=0", rsp_nack); end
        checks++; if (bus_q.size() !== 2 || bus_word() !== 32'h0000555C) begin errors++; $display("FAIL read_bytes got=%h/%0d exp=555c/2", bus_word(), bus_q.size()); end
        checks++; if (ack_q.size() !== 2 || ack_word() !== 8'h01) begin errors++; $display("FAIL read_acks got=%b/%0d exp=01/2", ack_word(), ack_q.size()); end
        checks++; if (scl_rises !== 19) begin errors++; $display("FAIL read_scl_rises got=%0d exp=19", scl_rises); end
    endtask

    task automatic test_addr_nack();
        int lat;
        clear_mon();
        run_cmd(1'b0, 7'h11, 8'h03, 8'h77, lat);
        checks++; if (lat !== 177) begin errors++; $display("FAIL nack_latency got=%0d exp=177", lat); end
        checks++; if (rsp_nack !== 1'b1) begin errors++; $display("FAIL nack_flag got=%b exp=1", rsp_nack); end
        checks++; if (bus_q.size() !== 1 || bus_word() !== 32'h00000022) begin errors++; $display("FAIL nack_bytes got=%h/%0d exp=22/1", bus_word(), bus_q.size()); end
        checks++; if (ack_q.size() !== 1 || ack_word() !== 8'h01) begin errors++; $display("FAIL nack_acks got=%b/%0d exp=1/1", ack_word(), ack_q.size()); end
        checks++; if (scl_rises !== 10) begin errors++; $display("FAIL nack_scl_rises got=%0d exp=10", scl_rises); end
        checks++; if (rsp_rdata !== 8'h5C) begin errors++; $display("FAIL nack_rdata_hold got=%h exp=5c", rsp_rdata); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int pulses;
        clear_mon();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev_addr = 7'h2A; cmd_reg_addr = 8'h07; cmd_wdata = 8'h81;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (21 * 16 + 6) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        rst = 1'b0;
        s_active = 1'b0; s_pull = 1'b0;
        #1;
        checks++; if (scl !== 1'b1) begin errors++; $display("FAIL mid_scl got=%b exp=1", scl); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL mid_sda got=%b exp=1", sda); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_busy_ready got=%b%b exp=01", busy, cmd_ready); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_no_rsp got=%0d exp=0", pulses); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        run_cmd(1'b0, 7'h2A, 8'h06, 8'h42, lat);
        checks++; if (lat !== 465 || rsp_nack !== 1'b0) begin errors++; $display("FAIL mid_next_cmd got=%0d/%b exp=465/0", lat, rsp_nack); end
        checks++; if (mem[6] !== 8'h42) begin errors++; $display("FAIL mid_next_mem got=%h exp=42", mem[6]); end
    endtask

    task automatic test_end_to_end();
        int lat;
        clear_mon();
        run_cmd(1'b0, 7'h2A, 8'h01, 8'h3C, lat);
        checks++; if (ack_word() !== 8'h00 || rsp_nack !== 1'b0) begin errors++; $display("FAIL e2e_write_acks got=%b/%b exp=000/0", ack_word(), rsp_nack); end
        clear_mon();
        run_cmd(1'b1, 7'h2A, 8'h00, 8'h00, lat);
        checks++; if (rsp_rdata !== 8'h3C || rsp_nack !== 1'b0) begin errors++; $display("FAIL e2e_read got=%h/%b exp=3c/0", rsp_rdata, rsp_nack); end
        checks++; if (ack_q.size() < 1 || ack_q[0] !== 1'b0) begin errors++; $display("FAIL e2e_read_addr_ack got=%b exp=0 (size %0d)", ack_word(), ack_q.size()); end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        clear_mon();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev_addr = 7'h2A; cmd_reg_addr = 8'h05; cmd_wdata = 8'h96;
        @(posedge clk);
        #1 cmd_rw = 1'b1; cmd_reg_addr = 8'h00; cmd_wdata = 8'h00;
        lat1 = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat1 = i;
                break;
            end
        end
        checks++; if (lat1 !== 465) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=465", lat1); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_during_rsp got=%b exp=0", cmd_ready); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_rsp got=%b exp=1", cmd_ready); end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got=%b exp=1", busy); end
        lat2 = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat2 = i;
                break;
            end
        end
        checks++; if (lat2 !== 321) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=321", lat2); end
        checks++; if (rsp_rdata !== 8'h96 || rsp_nack !== 1'b0) begin errors++; $display("FAIL b2b_read got=%h/%b exp=96/0", rsp_rdata, rsp_nack); end
        checks++; if (bus_q.size() !== 5 || bus_word() !== 32'h05965596) begin errors++; $display("FAIL b2b_bytes got=%h/%0d exp=05965596/5", bus_word(), bus_q.size()); end
        repeat (3) @(negedge clk);
        checks++; if (starts !== 2 || stops !== 2) begin errors++; $display("FAIL b2b_start_stop got=%0d/%0d exp=2/2", starts, stops); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_reset_mid();
        test_end_to_end();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
Single-master I2C bus driver that sits directly upstream of I2C_Slave and generates the SCL/SDA traffic it consumes. It takes one register-access command per handshake from a local controller. It serialises the command as START / address+RW / register address / data / STOP and returns read data and an ACK status. Standard-mode timing comes from the system clock; there is no multi-master arbitration and no clock stretching.

Parameters:
CLK_DIV, 250, system clocks per quarter SCL period (100 MHz clk -> 100 kHz SCL); legal range 2..65535
QW, $clog2(CLK_DIV), quarter-counter width (derived, not overridable)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  high when IDLE; a command is accepted on a cycle where cmd_valid && cmd_ready
cmd_rw  input  1  0 = write, 1 = read
cmd_dev_addr  input  7  target slave address
cmd_reg_addr  input  8  register address (write only)
cmd_wdata  input  8  write data
rsp_valid  output  1  one-cycle pulse at transaction end
rsp_nack  output  1  valid with rsp_valid; 1 = some slave ACK bit was sampled high
rsp_rdata  output  8  read byte, valid with rsp_valid when cmd_rw = 1
busy  output  1  high from command acceptance through rsp_valid
SCL  output  1  bus clock, push-pull
SDA  inout  1  open-drain: driven 0 or released to 'z; external pull-up

Behaviour:
- Reset (rst = 0, asynchronous):
  - SCL = 1, SDA = z, cmd_ready = 1, busy = 0, rsp_valid = 0, rsp_nack = 0, rsp_rdata = 0.
  - Quarter counter = 0; state = IDLE.
  - A reset mid-transaction releases the bus immediately; no STOP is generated.
- Quarter tick:
  - The counter runs 0..CLK_DIV-1 only while not IDLE; a tick fires at CLK_DIV-1.
  - Each bit slot is 4 quarters, Q0..Q3:
    - Q0: SCL = 0.
    - Q1: SCL = 0; SDA updated at its start.
    - Q2: SCL = 1.
    - Q3: SCL = 1; SDA sampled at its start.
- Command capture: all cmd_* fields are registered on acceptance and held stable internally.
- State sequence:
  - IDLE -> START on accept.
  - START (4 quarters): SDA released in Q0–Q1, SCL = 1 from Q0, SDA = 0 at Q2, SCL = 0 at the end of Q3.
  - ADDR (8 bits): shifts {dev_addr, rw}, MSB first.
  - ACK_A: SDA released, sample taken.
  - If write:
    - REG (8 bits) -> ACK_R -> WDATA (8 bits) -> ACK_D -> STOP.
  - If read:
    - RDATA (8 bits, SDA released, sampled MSB first into a shift register).
    - MNACK: master releases SDA (NACK).
    - STOP.
    - No register phase on reads: the read uses the slave's current address pointer.
  - STOP (4 quarters): SDA = 0 with SCL = 0 in Q0–Q1, SCL = 1 at Q2, SDA released at Q3.
  - STOP -> DONE (1 clk): rsp_valid = 1 -> IDLE.
- Any ACK sampled high: rsp_nack is set and the state goes directly to STOP after that ACK slot. Remaining bytes are skipped.
- Durations from accept cycle to rsp_valid:
  - Write: 29 slots × 4 × CLK_DIV + 1 clocks.
  - Read: 20 slots × 4 × CLK_DIV + 1.
  - Address-NACK: 11 × 4 × CLK_DIV + 1.
- cmd_valid while busy: ignored (cmd_ready = 0). A new command may be accepted the cycle after rsp_valid.
- SDA changes only while SCL = 0, except the START and STOP edges.
- rsp_rdata holds its value until the next read completes.

Decomposition:
- Package i2c_pkg:
  - State enum (IDLE, START, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_D, RDATA, MNACK, STOP, DONE).
  - Quarter-phase constants Q0..Q3.
  - RW encodings I2C_WR = 0, I2C_RD = 1.
  - Slot counts per transaction type.
- Sub-module i2c_clk_gen: quarter-period divider producing the tick and a 2-bit phase; enabled while not IDLE.
- Bit/byte sequencing stays in i2c_master.

Test Plan:
- CLK_DIV = 4, slave model ACKs; write dev 7'h2A, reg 8'h03, data 8'hA5 -> bus bytes 0x54, 0x03, 0xA5; rsp_valid at accept + 465 clocks; rsp_nack = 0; SCL/SDA idle high afterwards.
- Read dev 7'h2A after the write; slave drives 0x5C -> address byte 0x55; master releases SDA in the 9th slot; rsp_rdata = 0x5C; rsp_nack = 0; rsp_valid at accept + 321.
- No slave at 7'h11 -> ACK_A sampled 1 -> STOP follows immediately; rsp_nack = 1; rsp_valid at accept + 177; no further bytes driven.
- End-to-end with I2C_Slave instance (slave_addr 7'h2A): write reg 8'h01 = 8'h3C, then read -> rsp_rdata = 8'h3C; all ACKs low.
- Assert rst = 0 during the WDATA byte -> same cycle SCL = 1, SDA = z, busy = 0, cmd_ready = 1, no rsp_valid; the next command completes normally.
- Hold cmd_valid = 1 with two queued commands -> second accepted exactly 1 cycle after the first rsp_valid; a protocol monitor sees no SDA edge while SCL = 1 other than the START/STOP edges.
